// File: rtl/mem_to_reg_mux.sv
`default_nettype none
// ============================================================================
//  Module      : mem_to_reg_mux
//  Description : Write-back source selector for the MIPS32 datapath.
//                Chooses between the ALU result and the word read from RAM
//                and registers the chosen value as the register-file write
//                data. Sub-word loads (LH/LHU/LB/LBU) pick the addressed
//                halfword/byte out of the big-endian memory word and sign-
//                or zero-extend it to 32 bits.
//
//                Write-back data appears one cycle after the inputs are
//                sampled. wb_data only updates on valid cycles and holds
//                otherwise; wb_valid follows valid_in every cycle.
//
//  Options     : MEMTOREG_LINK_EN - adds link_sel/pc_plus8 so JAL/JALR can
//                write the return address (zero-extended pc_plus8), which
//                takes precedence over both the ALU and memory paths.
//
//  Ports       : CLK         in   clock, rising-edge
//                reset       in   synchronous, active-high reset
//                valid_in    in   qualifies this cycle's inputs
//                mem_to_reg  in   1 = memory data, 0 = ALU result
//                load_type   in   000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU,
//                                 101..111 behave as LW
//                byte_off    in   low two bits of the effective address
//                mem_data    in   RAM word, big-endian (byte 0 = [31:24])
//                alu_result  in   ALU output
//                link_sel    in   (MEMTOREG_LINK_EN) select return address
//                pc_plus8    in   (MEMTOREG_LINK_EN) 9-bit return address
//                wb_data     out  registered write-back value
//                wb_valid    out  registered copy of valid_in
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_to_reg_mux #(
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              valid_in,
   input  logic              mem_to_reg,
   input  logic [2:0]        load_type,
   input  logic [1:0]        byte_off,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] alu_result,
`ifdef MEMTOREG_LINK_EN
   input  logic              link_sel,
   input  logic [8:0]        pc_plus8,
`endif
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_valid
);

   // Load-type encodings
   localparam logic [2:0] c_LT_LW  = 3'b000;
   localparam logic [2:0] c_LT_LH  = 3'b001;
   localparam logic [2:0] c_LT_LHU = 3'b010;
   localparam logic [2:0] c_LT_LB  = 3'b011;
   localparam logic [2:0] c_LT_LBU = 3'b100;

   logic [15:0]       w_half;
   logic [7:0]        w_byte;
   logic [DATA_W-1:0] w_load_val;
   logic [DATA_W-1:0] w_next_data;
   logic [DATA_W-1:0] r_wb_data;
   logic              r_wb_valid;

   // Halfword select: only byte_off[1] matters; a misaligned halfword
   // address simply reads the halfword containing it (no trap here).
   always_comb begin
      w_half = byte_off[1] ? mem_data[15:0] : mem_data[31:16];
   end

   // Byte select, big-endian: offset 0 is the most significant byte.
   always_comb begin
      w_byte = mem_data[31:24];
      case (byte_off)
         2'd0:    w_byte = mem_data[31:24];
         2'd1:    w_byte = mem_data[23:16];
         2'd2:    w_byte = mem_data[15:8];
         default: w_byte = mem_data[7:0];
      endcase
   end

   // Extension according to load type; unused encodings fall back to LW so
   // the output is always defined.
   always_comb begin
      w_load_val = mem_data;
      case (load_type)
         c_LT_LW:  w_load_val = mem_data;
         c_LT_LH:  w_load_val = {{(DATA_W-16){w_half[15]}}, w_half};
         c_LT_LHU: w_load_val = {{(DATA_W-16){1'b0}}, w_half};
         c_LT_LB:  w_load_val = {{(DATA_W-8){w_byte[7]}}, w_byte};
         c_LT_LBU: w_load_val = {{(DATA_W-8){1'b0}}, w_byte};
         default:  w_load_val = mem_data;
      endcase
   end

   // Final source selection
   always_comb begin
      w_next_data = mem_to_reg ? w_load_val : alu_result;
`ifdef MEMTOREG_LINK_EN
      // Return address overrides everything for JAL/JALR.
      if (link_sel) begin
         w_next_data = {{(DATA_W-9){1'b0}}, pc_plus8};
      end
`endif
   end

   // Output register: reset wins over a simultaneous valid input, which is
   // then dropped. Data only loads on valid cycles.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_wb_data  <= '0;
         r_wb_valid <= 1'b0;
      end else begin
         r_wb_valid <= valid_in;
         if (valid_in) begin
            r_wb_data <= w_next_data;
         end
      end
   end

   assign wb_data  = r_wb_data;
   assign wb_valid = r_wb_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_to_reg_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_to_reg_mux
//  Description : Self-checking bench for mem_to_reg_mux. Each directed step
//                drives one cycle of inputs, pushes the expected outputs to
//                a scoreboard queue, and pops/compares them one clock later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_to_reg_mux;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        valid_in = 1'b0;
   logic        mem_to_reg = 1'b0;
   logic [2:0]  load_type = 3'd0;
   logic [1:0]  byte_off = 2'd0;
   logic [31:0] mem_data = 32'd0;
   logic [31:0] alu_result = 32'd0;
   logic        link_sel = 1'b0;
   logic [8:0]  pc_plus8 = 9'd0;
   logic [31:0] wb_data;
   logic        wb_valid;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] d;
      logic        v;
      string       tag;
   } exp_t;

   exp_t sb[$];

   mem_to_reg_mux #(.DATA_W(32)) dut (
      .CLK        (CLK),
      .reset      (reset),
      .valid_in   (valid_in),
      .mem_to_reg (mem_to_reg),
      .load_type  (load_type),
      .byte_off   (byte_off),
      .mem_data   (mem_data),
      .alu_result (alu_result),
`ifdef MEMTOREG_LINK_EN
      .link_sel   (link_sel),
      .pc_plus8   (pc_plus8),
`endif
      .wb_data    (wb_data),
      .wb_valid   (wb_valid)
   );

   always #5 CLK = ~CLK;

   // Independent reference: shift the addressed field down, then extend.
   function automatic logic [31:0] ref_load(input logic [2:0] lt,
                                            input logic [1:0] off,
                                            input logic [31:0] md);
      logic [31:0] h;
      logic [31:0] b;
      h = md >> (16 * (1 - int'(off[1])));
      b = md >> (8 * (3 - int'(off)));
      case (lt)
         3'd1:    ref_load = {{16{h[15]}}, h[15:0]};
         3'd2:    ref_load = {16'h0000, h[15:0]};
         3'd3:    ref_load = {{24{b[7]}}, b[7:0]};
         3'd4:    ref_load = {24'h000000, b[7:0]};
         default: ref_load = md;
      endcase
   endfunction

   // One cycle: drive, push expectation, clock, pop and compare.
   task automatic cyc(input logic rst, input logic v, input logic m2r,
                      input logic [2:0] lt, input logic [1:0] off,
                      input logic [31:0] md, input logic [31:0] alu,
                      input logic [31:0] exp_d, input string tag);
      exp_t e;
      exp_t got;
      reset      = rst;
      valid_in   = v;
      mem_to_reg = m2r;
      load_type  = lt;
      byte_off   = off;
      mem_data   = md;
      alu_result = alu;
      e.d   = exp_d;
      e.v   = rst ? 1'b0 : v;
      e.tag = tag;
      sb.push_back(e);
      @(posedge CLK);
      #1;
      got = sb.pop_front();
      checks++;
      assert (wb_data === got.d) else begin
         errors++;
         $error("FAIL %s wb_data: observed=%h expected=%h", got.tag, wb_data, got.d);
      end
      checks++;
      assert (wb_valid === got.v) else begin
         errors++;
         $error("FAIL %s wb_valid: observed=%b expected=%b", got.tag, wb_valid, got.v);
      end
   endtask

   initial begin
      logic [31:0] sweep_word;
      logic [31:0] last;
      #1;
      // Reset held for two edges with a valid input present
      cyc(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'h12345678, 32'h0, "reset1");
      cyc(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'h12345678, 32'h0, "reset2");
      cyc(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'h12345678, 32'h0, "idle");

      // ALU path then hold
      cyc(1'b0, 1'b1, 1'b0, 3'd3, 2'd1, 32'h11111111, 32'hDEADBEEF, 32'hDEADBEEF, "alu");
      cyc(1'b0, 1'b0, 1'b1, 3'd0, 2'd0, 32'h55555555, 32'h0BADF00D, 32'hDEADBEEF, "hold");

      // Word and sub-word loads
      cyc(1'b0, 1'b1, 1'b1, 3'd0, 2'd2, 32'h2401002C, 32'h0, 32'h2401002C, "lw");
      cyc(1'b0, 1'b1, 1'b1, 3'd3, 2'd1, 32'h11F28033, 32'h0, 32'hFFFFFFF2, "lb_off1");
      cyc(1'b0, 1'b1, 1'b1, 3'd4, 2'd1, 32'h11F28033, 32'h0, 32'h000000F2, "lbu_off1");
      cyc(1'b0, 1'b1, 1'b1, 3'd3, 2'd3, 32'h11F28033, 32'h0, 32'h00000033, "lb_off3");
      cyc(1'b0, 1'b1, 1'b1, 3'd1, 2'd0, 32'h8001FFFE, 32'h0, 32'hFFFF8001, "lh_off0");
      cyc(1'b0, 1'b1, 1'b1, 3'd2, 2'd2, 32'h8001FFFE, 32'h0, 32'h0000FFFE, "lhu_off2");
      cyc(1'b0, 1'b1, 1'b1, 3'd1, 2'd3, 32'h8001FFFE, 32'h0, 32'hFFFFFFFE, "lh_off3");
      cyc(1'b0, 1'b1, 1'b1, 3'd7, 2'd1, 32'hCAFE1234, 32'h0, 32'hCAFE1234, "lt7_as_lw");

      // Back-to-back alternating ALU / memory
      cyc(1'b0, 1'b1, 1'b0, 3'd3, 2'd0, 32'hA5A5A5A5, 32'h00000001, 32'h00000001, "b2b_alu1");
      cyc(1'b0, 1'b1, 1'b1, 3'd3, 2'd0, 32'hA5A5A5A5, 32'h00000002, 32'hFFFFFFA5, "b2b_mem1");
      cyc(1'b0, 1'b1, 1'b0, 3'd4, 2'd2, 32'h0000C300, 32'h00000003, 32'h00000003, "b2b_alu2");
      cyc(1'b0, 1'b1, 1'b1, 3'd4, 2'd2, 32'h0000C300, 32'h00000004, 32'h000000C3, "b2b_mem2");

      // Reset collides with a valid input: input is dropped
      cyc(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'h77777777, 32'h0, "rst_collide");
      // First valid input after reset appears one cycle later
      cyc(1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'h13579BDF, 32'h13579BDF, "post_rst");

      // Sweep every load type and offset against the reference model
      sweep_word = 32'h80FF7F01;
      for (int lt = 0; lt < 8; lt++) begin
         for (int off = 0; off < 4; off++) begin
            cyc(1'b0, 1'b1, 1'b1, 3'(lt), 2'(off), sweep_word, 32'h0,
                ref_load(3'(lt), 2'(off), sweep_word), "sweep");
         end
      end
      last = ref_load(3'd7, 2'd3, sweep_word);
      cyc(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, 32'h0, 32'hFFFFFFFF, last, "sweep_hold");

`ifdef MEMTOREG_LINK_EN
      link_sel = 1'b1;
      pc_plus8 = 9'h10C;
      cyc(1'b0, 1'b1, 1'b1, 3'd3, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000010C, "link");
      link_sel = 1'b0;
      cyc(1'b0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h0, 32'h00ABCDEF, 32'h00ABCDEF, "link_off");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Safety net so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: observed=no_finish expected=finish");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
